// File: rtl/stream_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_packer_pkg
//  Purpose  : Width helpers, parameter legality check and the packed-word
//             bundle shared between the stream packer and the write-DMA.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_packer_pkg;

  // Bits needed to index the next lane (at least one bit)
  function automatic int lane_cnt_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Lane count runs 1..R, so it needs one bit more than the lane index
  function automatic int count_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  // Queue occupancy runs 0..DEPTH
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when the width/depth combination is one the packer can build
  function automatic bit params_ok(input int in_w, input int out_w, input int depth);
    int lanes;
    if ((in_w < 1) || (out_w < in_w) || ((out_w % in_w) != 0)) return 1'b0;
    lanes = out_w / in_w;
    return is_pow2(lanes) && (lanes >= 2) && is_pow2(depth) && (depth >= 2);
  endfunction

  // Bundle as seen by the 256-bit write-DMA (16 lanes of 16 bits)
  localparam int DMA_OUT_WIDTH = 256;
  localparam int DMA_LANES     = 16;

  typedef struct packed {
    logic                       last;
    logic [$clog2(DMA_LANES):0] count;
    logic [DMA_OUT_WIDTH-1:0]   data;
  } packed_word_t;

endpackage
`default_nettype wire

// File: rtl/packer_word_queue.sv
`default_nettype none
// ============================================================================
//  Module   : packer_word_queue
//  Purpose  : Small FIFO of finished words with a registered head entry and
//             a registered occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module packer_word_queue
  import stream_packer_pkg::*;
#(
  parameter int WIDTH = 262,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  // Pointer/level update and look-ahead of the next head entry
  always_comb begin
    do_pop   = pop && (level_q != '0);
    // A pop on the same edge frees the slot, so a full queue may still push
    do_push  = push && ((level_q < LVL_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      head_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
      else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
      // The incoming word becomes head when it lands where the reader points
      if (level_d == '0)                          head_d = '0;
      else if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                        head_d = mem_q[rd_ptr_d];
    end
  end

  // Entry storage; contents are only ever read after being written
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

  // Control and head registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_packer
//  Purpose  : Gathers IN_WIDTH beats into OUT_WIDTH words with ready/valid on
//             both sides, explicit flush of partial words, and a small
//             output queue.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 256,
  parameter int OUT_DEPTH = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clr,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_WIDTH-1:0]                    in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_WIDTH-1:0]                   out_data,
  output logic [count_w(OUT_WIDTH/IN_WIDTH)-1:0] out_count,
  output logic                                   out_last,
  output logic [level_w(OUT_DEPTH)-1:0]          level
);

  localparam int LANES = OUT_WIDTH / IN_WIDTH;
  localparam int LCW   = lane_cnt_w(LANES);
  localparam int CW    = count_w(LANES);
  localparam int LVL_W = level_w(OUT_DEPTH);
  localparam int EW    = OUT_WIDTH + CW + 1;

  if (!params_ok(IN_WIDTH, OUT_WIDTH, OUT_DEPTH)) begin : g_param_check
    $error("stream_packer: illegal IN_WIDTH/OUT_WIDTH/OUT_DEPTH combination");
  end

  logic [LCW-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] lanes_q, lanes_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0] merged;
  logic                 room, accept, last_lane;
  logic                 push, push_last;
  logic [OUT_WIDTH-1:0] push_word;
  logic [CW-1:0]        push_count;
  logic [EW-1:0]        push_entry, head_entry;

  // Room is judged on registered occupancy only, never on out_ready
  assign room      = (level < LVL_W'(OUT_DEPTH));
  assign in_ready  = room && !flush_pend_q;
  assign accept    = in_valid && in_ready;
  assign last_lane = (cnt_q == LCW'(LANES - 1));
  assign out_valid = (level != '0);

  // Lane assembly, word completion and flush sequencing
  always_comb begin
    merged = lanes_q;
    merged[cnt_q*IN_WIDTH +: IN_WIDTH] = in_data;
    cnt_d        = cnt_q;
    lanes_d      = lanes_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_word    = '0;
    push_count   = '0;
    push_last    = 1'b0;
    if (clr) begin
      cnt_d        = '0;
      lanes_d      = '0;
      flush_pend_d = 1'b0;
    end else if (flush_pend_q) begin
      // Input is blocked while pending, so only the held lanes can be flushed
      if (room) begin
        if (cnt_q != '0) begin
          push       = 1'b1;
          push_word  = lanes_q;
          push_count = {1'b0, cnt_q};
          push_last  = 1'b1;
        end
        cnt_d        = '0;
        lanes_d      = '0;
        flush_pend_d = 1'b0;
      end
    end else if (accept) begin
      if (last_lane) begin
        // A flush on the completing beat just marks this word as last
        push       = 1'b1;
        push_word  = merged;
        push_count = CW'(LANES);
        push_last  = flush;
        cnt_d      = '0;
        lanes_d    = '0;
      end else begin
        cnt_d        = cnt_q + LCW'(1);
        lanes_d      = merged;
        flush_pend_d = flush;
      end
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
  end

  // Assembly state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      lanes_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      lanes_q      <= lanes_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign push_entry = {push_last, push_count, push_word};

  packer_word_queue #(
    .WIDTH (EW),
    .DEPTH (OUT_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (head_entry),
    .level     (level)
  );

  assign out_data  = head_entry[OUT_WIDTH-1:0];
  assign out_count = head_entry[OUT_WIDTH +: CW];
  assign out_last  = head_entry[EW-1];

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_packer
//  Purpose  : Self-checking bench for stream_packer (16 -> 256, depth 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

  localparam int R = 16;

  logic         clk = 1'b0;
  logic         reset, clr, flush, in_valid, out_ready;
  logic         in_ready, out_valid, out_last;
  logic [15:0]  in_data;
  logic [255:0] out_data;
  logic [4:0]   out_count;
  logic [1:0]   level;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: beats of the word being built and words not yet consumed
  logic [15:0]  cur[$];
  logic [255:0] exp_data[$];
  int           exp_cnt[$];
  bit           exp_last[$];
  bit           last_acc;
  int           words_seen = 0;

  stream_packer #(.IN_WIDTH(16), .OUT_WIDTH(256), .OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    cur.delete();
    exp_data.delete();
    exp_cnt.delete();
    exp_last.delete();
  endtask

  task automatic emit(input bit last);
    logic [255:0] w;
    w = '0;
    foreach (cur[i]) w[i*16 +: 16] = cur[i];
    exp_data.push_back(w);
    exp_cnt.push_back(cur.size());
    exp_last.push_back(last);
    cur.delete();
  endtask

  task automatic check_head();
    if (out_valid) begin
      check("head_expected", 256'(exp_data.size() != 0), 256'(1));
      if (exp_data.size() != 0) begin
        check("head_data", out_data, exp_data[0]);
        check("head_count", 256'(out_count), 256'(exp_cnt[0]));
        check("head_last", 256'(out_last), 256'(exp_last[0]));
      end
    end
    check("ready_when_full", 256'(in_ready && (level == 2'd2)), 256'(0));
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_valid"}, 256'(out_valid), 256'(0));
    check({pfx, "_level"}, 256'(level), 256'(0));
    check({pfx, "_in_ready"}, 256'(in_ready), 256'(1));
    check({pfx, "_data"}, out_data, 256'(0));
    check({pfx, "_count"}, 256'(out_count), 256'(0));
    check({pfx, "_last"}, 256'(out_last), 256'(0));
  endtask

  // One clock: drive just after a falling edge, update the model with what
  // the coming rising edge transfers, then check at the next falling edge.
  task automatic step(input bit v, input logic [15:0] d, input bit fl,
                      input bit ordy, input bit cl);
    in_valid = v; in_data = d; flush = fl; out_ready = ordy; clr = cl;
    last_acc = 1'b0;
    if (cl) begin
      model_clear();
    end else begin
      if (out_valid && ordy && (exp_data.size() != 0)) begin
        void'(exp_data.pop_front());
        void'(exp_cnt.pop_front());
        void'(exp_last.pop_front());
        words_seen++;
      end
      if (v && in_ready) begin
        cur.push_back(d);
        last_acc = 1'b1;
      end
      if (cur.size() == R)            emit(fl);
      else if (fl && cur.size() != 0) emit(1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    check_head();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 16'h0, 1'b0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (!out_valid && exp_data.size() == 0 && c > 2) break;
      idle(1'b1);
    end
    check("drain_model_empty", 256'(exp_data.size()), 256'(0));
    check("drain_out_valid", 256'(out_valid), 256'(0));
  endtask

  task automatic send_beats(input int n, input logic [15:0] base, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b1, base + 16'(i), 1'b0, ordy, 1'b0);
  endtask

  initial begin
    int nxt, w0;
    reset = 1'b1; clr = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Continuous stream, out_ready high, 1-cycle latency per word
    nxt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
      if (last_acc) nxt++;
      if (i == 14) check("cont_no_early_valid", 256'(out_valid), 256'(0));
      if (i == 15) begin
        check("cont_w0_valid", 256'(out_valid), 256'(1));
        check("cont_w0_lane15", 256'(out_data[255:240]), 256'(16'h000F));
        check("cont_w0_count", 256'(out_count), 256'(16));
      end
      if (i == 31) check("cont_w1_lane0", 256'(out_data[15:0]), 256'(16'h0010));
    end
    check("cont_throughput", 256'(nxt), 256'(32));
    drain();

    // Partial flush of 5 lanes, then next beat lands in lane 0
    send_beats(5, 16'hA000, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("pf_pend_blocks", 256'(in_ready), 256'(0));
    idle(1'b0);
    check("pf_valid", 256'(out_valid), 256'(1));
    check("pf_count", 256'(out_count), 256'(5));
    check("pf_last", 256'(out_last), 256'(1));
    check("pf_upper_zero", 256'(out_data[255:80]), 256'(0));
    idle(1'b1);
    step(1'b1, 16'hB000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("pf_next_lane0", 256'(out_data[15:0]), 256'(16'hB000));
    check("pf_next_count", 256'(out_count), 256'(1));
    drain();

    // Flush on the completing beat: one word, count 16, last set
    send_beats(15, 16'h5000, 1'b0);
    step(1'b1, 16'h500F, 1'b1, 1'b0, 1'b0);
    check("fc_count", 256'(out_count), 256'(16));
    check("fc_last", 256'(out_last), 256'(1));
    idle(1'b0); idle(1'b0);
    check("fc_single_word", 256'(level), 256'(1));
    check("fc_no_pend", 256'(in_ready), 256'(1));
    drain();

    // Backpressure: 48 beats offered with the sink stalled
    nxt = 0;
    w0 = words_seen;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 16'h3000 + 16'(nxt), 1'b0, 1'b0, 1'b0);
      if (last_acc) nxt++;
    end
    check("bp_accepted", 256'(nxt), 256'(32));
    check("bp_level", 256'(level), 256'(2));
    check("bp_in_ready", 256'(in_ready), 256'(0));
    for (int c = 0; c < 200 && nxt < 48; c++) begin
      step(1'b1, 16'h3000 + 16'(nxt), 1'b0, 1'b1, 1'b0);
      if (last_acc) nxt++;
    end
    check("bp_all_beats", 256'(nxt), 256'(48));
    drain();
    check("bp_words", 256'(words_seen - w0), 256'(3));

    // 3 lanes held behind one queued word, then flush
    send_beats(16, 16'h6000, 1'b0);
    send_beats(3, 16'h6100, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("fl3_level", 256'(level), 256'(2));
    idle(1'b1);
    check("fl3_count", 256'(out_count), 256'(3));
    check("fl3_last", 256'(out_last), 256'(1));
    drain();

    // Flush requested while the queue is full
    send_beats(32, 16'h7000, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("ff_in_ready", 256'(in_ready), 256'(0));
    idle(1'b0); idle(1'b0);
    check("ff_level_held", 256'(level), 256'(2));
    check("ff_pend_held", 256'(in_ready), 256'(0));
    idle(1'b1);
    check("ff_level_after_pop", 256'(level), 256'(1));
    check("ff_pend_after_pop", 256'(in_ready), 256'(0));
    idle(1'b0);
    check("ff_no_empty_word", 256'(level), 256'(1));
    check("ff_ready_back", 256'(in_ready), 256'(1));
    drain();

    // Synchronous clear mid-word with a word queued
    send_beats(20, 16'h8000, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    check_idle("clr");
    step(1'b1, 16'hC000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("clr_next_lane0", 256'(out_data[15:0]), 256'(16'hC000));
    drain();

    // Asynchronous reset between edges, mid-word with a word queued
    send_beats(18, 16'h9000, 1'b0);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_idle("areset");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    step(1'b1, 16'hC100, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("areset_next_lane0", 256'(out_data[15:0]), 256'(16'hC100));
    check("areset_next_count", 256'(out_count), 256'(1));
    drain();

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 199) == 0);
    end
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
